// File: rtl/control_unit_pkg.sv
// Shared definitions for the accumulator-processor control unit.
//  - opcode values (top OP_W bits of the instruction word)
//  - UAL function select codes
//  - FSM state encoding
package control_unit_pkg;

  localparam int OP_NOR = 0;
  localparam int OP_ADD = 1;
  localparam int OP_STA = 2;
  localparam int OP_JCC = 3;  // jump if carry == 0
  localparam int OP_LDA = 4;
  localparam int OP_JMP = 5;
  localparam int OP_JZ  = 6;  // jump if zero == 1
  localparam int OP_HLT = 7;

  localparam int UAL_PASS = 0;
  localparam int UAL_NOR  = 1;
  localparam int UAL_ADD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_EXEC2  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/prog_counter_gen.sv
// Program counter with synchronous clear / load / increment.
// Priority: clear > load > increment; all updates gated by ce.
// Increment wraps modulo 2^ADR_W with no flag.
// Ports:
//  clk, rst (sync, active-high), ce
//  clear, load, inc   update requests
//  load_val           jump target
//  pc                 current program counter
module prog_counter_gen #(
  parameter int ADR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [ADR_W-1:0] load_val,
  output logic [ADR_W-1:0] pc
);

  logic [ADR_W-1:0] pc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= '0;
    end else if (ce) begin
      if (clear)
        pc_reg <= '0;
      else if (load)
        pc_reg <= load_val;
      else if (inc)
        pc_reg <= pc_reg + ADR_W'(1);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/control_unit_gen.sv
// Control unit for the accumulator processor: sequences
// fetch/decode/execute, owns PC and RI, drives the memory address mux
// and the datapath strobes. Memory accesses wait on mem_ready.
// Ports:
//  clk, rst (sync, active-high), ce (freezes state, forces strobes to 0)
//  boot        start request, sampled in IDLE
//  mem_ready   memory access completes this cycle
//  carry, zero datapath flags used by JCC / JZ
//  data_in     memory read data (instruction during fetch)
//  adr         PC in FETCH/other states, RI address field in EXEC
//  enable_mem, w_mem, load_R1, load_accu, load_carry, clear_carry  strobes
//  sel_UAL     UAL function (PASS except in EXEC2)
//  halted      high while in HALT
import control_unit_pkg::*;

module control_unit_gen #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16,
  parameter int OP_W   = 3,
  parameter int UAL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              boot,
  input  logic              mem_ready,
  input  logic              carry,
  input  logic              zero,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADR_W-1:0]  adr,
  output logic              enable_mem,
  output logic              w_mem,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              clear_carry,
  output logic [UAL_W-1:0]  sel_UAL,
  output logic              halted
);

  state_t           state_reg;
  logic [OP_W-1:0]  op_reg;
  logic [ADR_W-1:0] ri_adr_reg;
  logic [ADR_W-1:0] pc_val;

  logic is_nor, is_add, is_sta, is_jcc, is_lda, is_jmp, is_jz, is_hlt;
  logic jump_taken;

  assign is_nor = (op_reg == OP_W'(OP_NOR));
  assign is_add = (op_reg == OP_W'(OP_ADD));
  assign is_sta = (op_reg == OP_W'(OP_STA));
  assign is_jcc = (op_reg == OP_W'(OP_JCC));
  assign is_lda = (op_reg == OP_W'(OP_LDA));
  assign is_jmp = (op_reg == OP_W'(OP_JMP));
  assign is_jz  = (op_reg == OP_W'(OP_JZ));
  assign is_hlt = (op_reg == OP_W'(OP_HLT));

  assign jump_taken = is_jmp | (is_jcc & ~carry) | (is_jz & zero);

  // Instruction bits between the opcode and the address field carry no meaning.
  generate
    if (DATA_W > OP_W + ADR_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^data_in[DATA_W-OP_W-1:ADR_W];
    end
  endgenerate

  // Sequencer; RI is captured on the fetch completion edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= '0;
      ri_adr_reg <= '0;
    end else if (ce) begin
      case (state_reg)
        ST_IDLE: begin
          if (boot)
            state_reg <= ST_FETCH;
        end
        ST_FETCH: begin
          if (mem_ready) begin
            op_reg     <= data_in[DATA_W-1 -: OP_W];
            ri_adr_reg <= data_in[ADR_W-1:0];
            state_reg  <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_hlt)
            state_reg <= ST_HALT;
          else if (is_nor | is_add | is_lda | is_sta)
            state_reg <= ST_EXEC;
          else
            state_reg <= ST_FETCH;
        end
        ST_EXEC: begin
          if (mem_ready)
            state_reg <= (is_nor | is_add) ? ST_EXEC2 : ST_FETCH;
        end
        ST_EXEC2: state_reg <= ST_FETCH;
        ST_HALT:  state_reg <= ST_HALT;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // PC control: the increment happens in FETCH, so a jump decoded next
  // cycle simply overwrites the (possibly wrapped) value.
  logic pc_clear, pc_load, pc_inc;
  assign pc_clear = (state_reg == ST_IDLE);
  assign pc_load  = (state_reg == ST_DECODE) & jump_taken;
  assign pc_inc   = (state_reg == ST_FETCH) & mem_ready;

  prog_counter_gen #(.ADR_W(ADR_W)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .clear    (pc_clear),
    .load     (pc_load),
    .inc      (pc_inc),
    .load_val (ri_adr_reg),
    .pc       (pc_val)
  );

  // Raw strobe decode (Mealy on mem_ready / carry), gated by ce below.
  logic em_next, wm_next, r1_next, ac_next, lc_next, cc_next;

  always_comb begin
    em_next = 1'b0;
    wm_next = 1'b0;
    r1_next = 1'b0;
    ac_next = 1'b0;
    lc_next = 1'b0;
    cc_next = 1'b0;
    sel_UAL = UAL_W'(UAL_PASS);
    case (state_reg)
      ST_FETCH:  em_next = 1'b1;
      ST_DECODE: cc_next = is_jcc & carry;
      ST_EXEC: begin
        em_next = 1'b1;
        wm_next = is_sta;
        r1_next = mem_ready & (is_nor | is_add);
        ac_next = mem_ready & is_lda;
      end
      ST_EXEC2: begin
        ac_next = 1'b1;
        lc_next = is_add;
        sel_UAL = is_add ? UAL_W'(UAL_ADD) : UAL_W'(UAL_NOR);
      end
      default: ;
    endcase
  end

  assign enable_mem  = ce & em_next;
  assign w_mem       = ce & wm_next;
  assign load_R1     = ce & r1_next;
  assign load_accu   = ce & ac_next;
  assign load_carry  = ce & lc_next;
  assign clear_carry = ce & cc_next;

  assign adr    = (state_reg == ST_EXEC) ? ri_adr_reg : pc_val;
  assign halted = (state_reg == ST_HALT);

endmodule

// File: tb/tb_control_unit_gen.sv
// Cycle-level bench: each driven cycle pushes its expected output vector;
// a negedge monitor pops and compares against the DUT.
module tb_control_unit_gen;

  logic        clk = 1'b0;
  logic        rst, ce, boot, mem_ready, carry, zero;
  logic [15:0] data_in;
  logic [5:0]  adr;
  logic        enable_mem, w_mem, load_R1, load_accu, load_carry, clear_carry, halted;
  logic [2:0]  sel_UAL;

  always #5 clk = ~clk;

  control_unit_gen #(.ADR_W(6), .DATA_W(16), .OP_W(3), .UAL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .boot        (boot),
    .mem_ready   (mem_ready),
    .carry       (carry),
    .zero        (zero),
    .data_in     (data_in),
    .adr         (adr),
    .enable_mem  (enable_mem),
    .w_mem       (w_mem),
    .load_R1     (load_R1),
    .load_accu   (load_accu),
    .load_carry  (load_carry),
    .clear_carry (clear_carry),
    .sel_UAL     (sel_UAL),
    .halted      (halted)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;

  // {halted, enable_mem, w_mem, load_R1, load_accu, load_carry, clear_carry, sel_UAL, adr}
  function automatic logic [15:0] ov(input logic em, input logic wm, input logic r1,
                                     input logic ac, input logic lc, input logic cc,
                                     input logic [2:0] ual, input logic [5:0] a,
                                     input logic h);
    ov = {h, em, wm, r1, ac, lc, cc, ual, a};
  endfunction

  function automatic logic [15:0] instr(input logic [2:0] op, input logic [5:0] a);
    instr = {op, 7'h55, a};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end else begin
      $display("ok   %s: %04h", tag, got);
    end
  endtask

  // One transaction per clock: inputs already set, expectation queued.
  task automatic cyc(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check(e.tag, {halted, enable_mem, w_mem, load_R1, load_accu, load_carry,
                    clear_carry, sel_UAL, adr}, e.exp);
    end
  end

  initial begin
    rst = 1'b1; ce = 1'b1; boot = 1'b0; mem_ready = 1'b0;
    carry = 1'b0; zero = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst_hold", 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc("idle", 16'h0000);

    boot = 1'b1; cyc("boot_idle", 16'h0000);
    boot = 1'b0;
    for (int i = 0; i < 3; i++) cyc("fetch_wait", ov(1,0,0,0,0,0,0,6'h00,0));
    mem_ready = 1'b1; data_in = instr(3'd3, 6'h15);
    cyc("fetch_rdy", ov(1,0,0,0,0,0,0,6'h00,0));

    // JCC with carry=1: no jump, carry cleared
    mem_ready = 1'b0; carry = 1'b1;
    cyc("jcc_c1", ov(0,0,0,0,0,1,0,6'h01,0));
    carry = 1'b0; mem_ready = 1'b1; data_in = instr(3'd3, 6'h15);
    cyc("fetch_pc1", ov(1,0,0,0,0,0,0,6'h01,0));
    mem_ready = 1'b0;
    cyc("jcc_c0", ov(0,0,0,0,0,0,0,6'h02,0));

    // ADD 0x2A
    mem_ready = 1'b1; data_in = instr(3'd1, 6'h2A);
    cyc("fetch_jt", ov(1,0,0,0,0,0,0,6'h15,0));
    cyc("add_dec", ov(0,0,0,0,0,0,0,6'h16,0));
    cyc("add_exec", ov(1,0,1,0,0,0,0,6'h2A,0));
    mem_ready = 1'b0;
    cyc("add_exec2", ov(0,0,0,1,1,0,3'd2,6'h16,0));

    // STA 0x10 with two wait states, then a ce=0 freeze
    mem_ready = 1'b1; data_in = instr(3'd2, 6'h10);
    cyc("fetch_sta", ov(1,0,0,0,0,0,0,6'h16,0));
    mem_ready = 1'b0;
    cyc("sta_dec", ov(0,0,0,0,0,0,0,6'h17,0));
    for (int i = 0; i < 2; i++) cyc("sta_wait", ov(1,1,0,0,0,0,0,6'h10,0));
    ce = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) cyc("sta_ce0", ov(0,0,0,0,0,0,0,6'h10,0));
    ce = 1'b1;
    cyc("sta_rdy", ov(1,1,0,0,0,0,0,6'h10,0));

    // LDA 0x05
    data_in = instr(3'd4, 6'h05);
    cyc("fetch_lda", ov(1,0,0,0,0,0,0,6'h17,0));
    cyc("lda_dec", ov(0,0,0,0,0,0,0,6'h18,0));
    cyc("lda_exec", ov(1,0,0,1,0,0,0,6'h05,0));

    // JZ 0x3F, first not taken then taken
    data_in = instr(3'd6, 6'h3F);
    cyc("fetch_jz", ov(1,0,0,0,0,0,0,6'h18,0));
    cyc("jz_z0", ov(0,0,0,0,0,0,0,6'h19,0));
    cyc("fetch_jz2", ov(1,0,0,0,0,0,0,6'h19,0));
    zero = 1'b1;
    cyc("jz_z1", ov(0,0,0,0,0,0,0,6'h1A,0));
    zero = 1'b0;

    // NOR at address 63: PC wraps to 0
    data_in = instr(3'd0, 6'h01);
    cyc("fetch_top", ov(1,0,0,0,0,0,0,6'h3F,0));
    cyc("nor_dec_wrap", ov(0,0,0,0,0,0,0,6'h00,0));
    cyc("nor_exec", ov(1,0,1,0,0,0,0,6'h01,0));
    cyc("nor_exec2", ov(0,0,0,1,0,0,3'd1,6'h00,0));

    // JMP to 63, then JMP from 63 during the wrap
    data_in = instr(3'd5, 6'h3F);
    cyc("fetch_jmp", ov(1,0,0,0,0,0,0,6'h00,0));
    cyc("jmp_dec", ov(0,0,0,0,0,0,0,6'h01,0));
    data_in = instr(3'd5, 6'h20);
    cyc("fetch_jmp_top", ov(1,0,0,0,0,0,0,6'h3F,0));
    cyc("jmp_dec_wrap", ov(0,0,0,0,0,0,0,6'h00,0));

    // HLT, boot ignored, rst (with ce=0) exits
    data_in = instr(3'd7, 6'h00);
    cyc("fetch_hlt", ov(1,0,0,0,0,0,0,6'h20,0));
    cyc("hlt_dec", ov(0,0,0,0,0,0,0,6'h21,0));
    for (int i = 0; i < 3; i++) begin
      boot = (i != 1);
      cyc("halt", ov(0,0,0,0,0,0,0,6'h21,1));
    end
    boot = 1'b0; rst = 1'b1; ce = 1'b0;
    cyc("halt_rst", ov(0,0,0,0,0,0,0,6'h21,1));
    rst = 1'b0; ce = 1'b1;
    cyc("post_rst", 16'h0000);

    // rst mid-EXEC
    boot = 1'b1; cyc("boot2", 16'h0000);
    boot = 1'b0; mem_ready = 1'b1; data_in = instr(3'd2, 6'h33);
    cyc("fetch_sta2", ov(1,0,0,0,0,0,0,6'h00,0));
    mem_ready = 1'b0;
    cyc("sta2_dec", ov(0,0,0,0,0,0,0,6'h01,0));
    cyc("sta2_wait", ov(1,1,0,0,0,0,0,6'h33,0));
    rst = 1'b1;
    cyc("sta2_rst", ov(1,1,0,0,0,0,0,6'h33,0));
    rst = 1'b0;
    cyc("rst_idle", 16'h0000);

    @(negedge clk);
    #1;
    check("sb_drain", 16'(sb.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
